// File: rtl/gpr_pkg.sv
// Shared constants and helpers for the parametrised GPR file and its scoreboard.
package gpr_pkg;

   localparam int RV_XLEN    = 32;
   localparam int RV_NUM_GPR = 32;
   localparam int ZERO_ADDR  = 0;

   // Address width that stays at least 1 bit, even for a two-entry file.
   function automatic int clog2_safe(input int n);
      int w;
      w = 1;
      while ((1 << w) < n) w = w + 1;
      return w;
   endfunction

   // A register address is live when it is in range and not the hard-wired zero register.
   function automatic logic gpr_addr_ok(input int addr, input int num_regs, input int zero_reg);
      return (addr < num_regs) && !((zero_reg != 0) && (addr == ZERO_ADDR));
   endfunction

endpackage

// File: rtl/gpr_scoreboard.sv
// Per-register busy bits: writeback clears, issue reserves, and a same-cycle reserve wins.
module gpr_scoreboard
   import gpr_pkg::*;
#(
   parameter int NUM_REGS = RV_NUM_GPR,
   parameter int ZERO_REG = 1,
   localparam int ADDR_W  = clog2_safe(NUM_REGS)
) (
   input  logic                clock,
   input  logic                reset_n,
   input  logic                write_enable,
   input  logic [ADDR_W-1:0]   write_addr,
   input  logic                rsv_en,
   input  logic [ADDR_W-1:0]   rsv_addr,
   output logic [NUM_REGS-1:0] busy_q,
   output logic [NUM_REGS-1:0] busy_next
);

   logic wr_ok;
   logic rsv_ok;

   assign wr_ok  = write_enable && gpr_addr_ok(int'(write_addr), NUM_REGS, ZERO_REG);
   assign rsv_ok = rsv_en && gpr_addr_ok(int'(rsv_addr), NUM_REGS, ZERO_REG);

   // Reserve is applied after the clear so a new producer overrides the retiring one.
   always_comb begin
      busy_next = busy_q;
      if (wr_ok)  busy_next[write_addr] = 1'b0;
      if (rsv_ok) busy_next[rsv_addr]   = 1'b1;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) busy_q <= '0;
      else          busy_q <= busy_next;
   end

endmodule

// File: rtl/gpr_file_mp.sv
// Multi-read-port GPR file with synchronous write-first reads and a busy scoreboard.
module gpr_file_mp
   import gpr_pkg::*;
#(
   parameter int WORD_SIZE = RV_XLEN,
   parameter int NUM_REGS  = RV_NUM_GPR,
   parameter int NUM_RD    = 2,
   parameter int ZERO_REG  = 1,
   localparam int ADDR_W   = clog2_safe(NUM_REGS)
) (
   input  logic                        clock,
   input  logic                        reset_n,
   input  logic                        write_enable,
   input  logic [ADDR_W-1:0]           write_addr,
   input  logic [WORD_SIZE-1:0]        write_data,
   input  logic                        rsv_en,
   input  logic [ADDR_W-1:0]           rsv_addr,
   input  logic [NUM_RD-1:0]           rd_en,
   input  logic [NUM_RD*ADDR_W-1:0]    read_addr,
   output logic [NUM_RD*WORD_SIZE-1:0] read_data,
   output logic [NUM_RD-1:0]           read_valid,
   output logic [NUM_RD-1:0]           read_busy,
   output logic [NUM_REGS-1:0]         busy_vec
);

   // Storage is padded to the full address space so any read index is legal; padding never loads.
   localparam int DEPTH = 1 << ADDR_W;

   logic [WORD_SIZE-1:0] regs [DEPTH];
   logic                 wr_ok;
   logic [NUM_REGS-1:0]  busy_next;
   logic [DEPTH-1:0]     busy_ext;

   assign wr_ok    = write_enable && gpr_addr_ok(int'(write_addr), NUM_REGS, ZERO_REG);
   assign busy_ext = DEPTH'(busy_next);

   gpr_scoreboard #(
      .NUM_REGS (NUM_REGS),
      .ZERO_REG (ZERO_REG)
   ) u_scoreboard (
      .clock        (clock),
      .reset_n      (reset_n),
      .write_enable (write_enable),
      .write_addr   (write_addr),
      .rsv_en       (rsv_en),
      .rsv_addr     (rsv_addr),
      .busy_q       (busy_vec),
      .busy_next    (busy_next)
   );

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      end else if (wr_ok) begin
         regs[write_addr] <= write_data;
      end
   end

   for (genvar p = 0; p < NUM_RD; p++) begin : g_port
      logic [ADDR_W-1:0]    addr_p0;
      logic                 rd_ok_p0;
      logic [WORD_SIZE-1:0] data_p0;
      logic [WORD_SIZE-1:0] data_p1;
      logic                 busy_p1;
      logic                 vld_p1;

      // p0: address decode and write-first bypass
      assign addr_p0  = read_addr[p*ADDR_W +: ADDR_W];
      assign rd_ok_p0 = gpr_addr_ok(int'(addr_p0), NUM_REGS, ZERO_REG);

      always_comb begin
         data_p0 = '0;
         if (rd_ok_p0) data_p0 = (wr_ok && (write_addr == addr_p0)) ? write_data : regs[addr_p0];
      end

      // p1: per-port output registers
      always_ff @(posedge clock or negedge reset_n) begin
         if (!reset_n) begin
            data_p1 <= '0;
            busy_p1 <= 1'b0;
            vld_p1  <= 1'b0;
         end else begin
            vld_p1 <= rd_en[p];
            if (rd_en[p]) begin
               data_p1 <= data_p0;
               busy_p1 <= rd_ok_p0 & busy_ext[addr_p0];
            end
         end
      end

      assign read_data[p*WORD_SIZE +: WORD_SIZE] = data_p1;
      assign read_busy[p]                        = busy_p1;
      assign read_valid[p]                       = vld_p1;
   end

endmodule
